// File: rtl/interface_coprocessador_if.sv
// Host instruction/response bus of the matrix coprocessor initiator.
// master = host (HPS/PIO bridge), slave = interface_coprocessador.
interface interface_coprocessador_if #(
    parameter int ELEM_W = 8
) ();
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ELEM_W-1:0] rdata;
    logic              rdata_valid;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready,
        input  rdata,
        input  rdata_valid
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready,
        output rdata,
        output rdata_valid
    );
endinterface

// File: rtl/interface_coprocessador.sv
// Host-side initiator for the 5x5 matrix coprocessor: assembles A/B from
// LOAD instructions, runs EXEC with a done timeout, and serves READs of the result.
module interface_coprocessador #(
    parameter int ELEM_W  = 8,
    parameter int N_ELEM  = 25,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    interface_coprocessador_if.slave   host,
    output logic                       busy,
    output logic                       flag_done,
    output logic                       flag_ovf,
    output logic                       flag_err,
    output logic                       cop_start,
    output logic [2:0]                 cop_op,
    output logic [2:0]                 cop_tamanho,
    output logic [N_ELEM*ELEM_W-1:0]   cop_matriz1,
    output logic [N_ELEM*ELEM_W-1:0]   cop_matriz2,
    input  logic [N_ELEM*ELEM_W-1:0]   cop_result,
    input  logic                       cop_overflow,
    input  logic                       cop_done
);
    localparam int MAT_W = N_ELEM * ELEM_W;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [4:0] IDX_MAX = 5'(N_ELEM - 1);

    localparam logic [1:0] CMD_LOAD_A = 2'b00;
    localparam logic [1:0] CMD_LOAD_B = 2'b01;
    localparam logic [1:0] CMD_EXEC   = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [MAT_W-1:0]  mat_a_r;
    logic [MAT_W-1:0]  mat_b_r;
    logic [MAT_W-1:0]  result_r;
    logic [ELEM_W-1:0] rdata_r;
    logic              rdata_valid_r;
    logic              instr_ready_r;
    logic              busy_r;
    logic              flag_done_r;
    logic              flag_ovf_r;
    logic              flag_err_r;
    logic              cop_start_r;
    logic [2:0]        cop_op_r;
    logic [2:0]        cop_tamanho_r;

    logic [1:0]        cmd_s;
    logic [4:0]        idx_s;
    logic [ELEM_W-1:0] data_s;
    logic              accept_s;
    logic              idx_bad_s;
    logic              unused_instr_s;

    function automatic logic [ELEM_W-1:0] elem_rd(input logic [MAT_W-1:0] m,
                                                  input logic [4:0]       idx);
        logic [ELEM_W-1:0] v;
        v = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            if (idx == 5'(k)) v = m[k*ELEM_W +: ELEM_W];
        end
        return v;
    endfunction

    function automatic logic [MAT_W-1:0] elem_wr(input logic [MAT_W-1:0]  m,
                                                 input logic [4:0]        idx,
                                                 input logic [ELEM_W-1:0] d);
        logic [MAT_W-1:0] r;
        r = m;
        for (int k = 0; k < N_ELEM; k++) begin
            if (idx == 5'(k)) r[k*ELEM_W +: ELEM_W] = d;
        end
        return r;
    endfunction

    assign cmd_s          = host.instr[31:30];
    assign idx_s          = host.instr[12:8];
    assign data_s         = host.instr[ELEM_W-1:0];
    assign accept_s       = host.instr_valid & instr_ready_r;
    assign idx_bad_s      = (idx_s > IDX_MAX);
    assign unused_instr_s = ^host.instr[29:13];

    // Command decode, IDLE->START->WAIT_DONE sequencing and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            cnt_r         <= '0;
            mat_a_r       <= '0;
            mat_b_r       <= '0;
            result_r      <= '0;
            rdata_r       <= '0;
            rdata_valid_r <= 1'b0;
            instr_ready_r <= 1'b1;
            busy_r        <= 1'b0;
            flag_done_r   <= 1'b0;
            flag_ovf_r    <= 1'b0;
            flag_err_r    <= 1'b0;
            cop_start_r   <= 1'b0;
            cop_op_r      <= 3'd0;
            cop_tamanho_r <= 3'd0;
        end else begin
            cop_start_r   <= 1'b0;
            rdata_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        case (cmd_s)
                            CMD_LOAD_A: begin
                                if (idx_bad_s) flag_err_r <= 1'b1;
                                else           mat_a_r    <= elem_wr(mat_a_r, idx_s, data_s);
                            end
                            CMD_LOAD_B: begin
                                if (idx_bad_s) flag_err_r <= 1'b1;
                                else           mat_b_r    <= elem_wr(mat_b_r, idx_s, data_s);
                            end
                            CMD_EXEC: begin
                                cop_op_r      <= host.instr[2:0];
                                cop_tamanho_r <= host.instr[5:3];
                                flag_done_r   <= 1'b0;
                                flag_ovf_r    <= 1'b0;
                                flag_err_r    <= 1'b0;
                                cop_start_r   <= 1'b1;
                                instr_ready_r <= 1'b0;
                                busy_r        <= 1'b1;
                                state_r       <= S_START;
                            end
                            CMD_READ: begin
                                rdata_valid_r <= 1'b1;
                                if (idx_bad_s) begin
                                    rdata_r    <= '0;
                                    flag_err_r <= 1'b1;
                                end else begin
                                    rdata_r    <= elem_rd(result_r, idx_s);
                                end
                            end
                            default: state_r <= S_IDLE;
                        endcase
                    end
                end
                S_START: begin
                    cnt_r   <= '0;
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it wins over a simultaneous timeout
                    if (cop_done) begin
                        result_r      <= cop_result;
                        flag_ovf_r    <= cop_overflow;
                        flag_done_r   <= 1'b1;
                        instr_ready_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= S_IDLE;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        flag_err_r    <= 1'b1;
                        instr_ready_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    instr_ready_r <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= S_IDLE;
                end
            endcase
        end
    end

    assign host.instr_ready = instr_ready_r;
    assign host.rdata       = rdata_r;
    assign host.rdata_valid = rdata_valid_r;
    assign busy             = busy_r;
    assign flag_done        = flag_done_r;
    assign flag_ovf         = flag_ovf_r;
    assign flag_err         = flag_err_r;
    assign cop_start        = cop_start_r;
    assign cop_op           = cop_op_r;
    assign cop_tamanho      = cop_tamanho_r;
    assign cop_matriz1      = mat_a_r;
    assign cop_matriz2      = mat_b_r;
endmodule

// File: tb/tb_interface_coprocessador.sv
// Bench for interface_coprocessador: directed scenarios plus random instruction
// streams, checked every cycle against a timeline-based behavioural model.
module tb_interface_coprocessador;
    localparam int W  = 8;
    localparam int N  = 25;
    localparam int TO = 64;
    localparam int MW = N * W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    interface_coprocessador_if #(.ELEM_W(W)) host_if ();

    logic          busy, flag_done, flag_ovf, flag_err, cop_start;
    logic [2:0]    cop_op, cop_tamanho;
    logic [MW-1:0] cop_matriz1, cop_matriz2, cop_result;
    logic          cop_overflow, cop_done;

    interface_coprocessador #(.ELEM_W(W), .N_ELEM(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (host_if),
        .busy         (busy),
        .flag_done    (flag_done),
        .flag_ovf     (flag_ovf),
        .flag_err     (flag_err),
        .cop_start    (cop_start),
        .cop_op       (cop_op),
        .cop_tamanho  (cop_tamanho),
        .cop_matriz1  (cop_matriz1),
        .cop_matriz2  (cop_matriz2),
        .cop_result   (cop_result),
        .cop_overflow (cop_overflow),
        .cop_done     (cop_done)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: plain arrays plus the edge number at which an EXEC ends
    logic [7:0] m_a [N];
    logic [7:0] m_b [N];
    logic [7:0] m_r [N];
    bit         m_busy, m_done, m_ovf, m_err, m_start, m_rvalid, m_cop_en;
    bit         exec_cop_en;
    logic [7:0] m_rdata;
    logic [2:0] m_op, m_tam;
    int         n_edge, m_end;
    logic [MW-1:0] pa, pb;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_a[k] = 8'h00; m_b[k] = 8'h00; m_r[k] = 8'h00;
        end
        m_busy = 0; m_done = 0; m_ovf = 0; m_err = 0;
        m_start = 0; m_rvalid = 0; m_cop_en = 0;
        m_rdata = 8'h00; m_op = 3'd0; m_tam = 3'd0;
    endtask

    task automatic model_accept(input logic [31:0] w);
        logic [4:0] idx;
        idx = w[12:8];
        case (w[31:30])
            2'b00: if (idx < N) m_a[idx] = w[7:0]; else m_err = 1;
            2'b01: if (idx < N) m_b[idx] = w[7:0]; else m_err = 1;
            2'b10: begin
                m_op = w[2:0]; m_tam = w[5:3];
                m_done = 0; m_ovf = 0; m_err = 0;
                m_start = 1; m_busy = 1; m_cop_en = exec_cop_en;
                // start next cycle, done 3 cycles later; otherwise TIMEOUT wait cycles
                m_end = n_edge + (exec_cop_en ? 4 : TO + 1);
            end
            default: begin
                m_rvalid = 1;
                if (idx < N) m_rdata = m_r[idx];
                else begin m_rdata = 8'h00; m_err = 1; end
            end
        endcase
    endtask

    task automatic model_finish();
        int s;
        if (m_cop_en) begin
            m_ovf = 0;
            for (int k = 0; k < N; k++) begin
                s = int'($signed(m_a[k])) + int'($signed(m_b[k]));
                m_r[k] = s[7:0];
                if (s > 127 || s < -128) m_ovf = 1;
            end
            m_done = 1;
        end else begin
            m_err = 1;
        end
        m_busy = 0;
    endtask

    initial begin : model
        n_edge = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                n_edge++;
                m_start = 0; m_rvalid = 0;
                if (!m_busy && host_if.instr_valid) model_accept(host_if.instr);
                else if (m_busy && n_edge == m_end) model_finish();
            end
        end
    end

    // Coprocessor stand-in: elementwise signed add, done 3 cycles after start
    initial begin : cop
        logic [MW-1:0] res;
        logic          ovf;
        int            s;
        cop_done = 1'b0; cop_overflow = 1'b0; cop_result = '0;
        forever begin
            @(posedge clk);
            if (rst_n && cop_start && m_cop_en) begin
                ovf = 1'b0;
                for (int k = 0; k < N; k++) begin
                    s = int'($signed(cop_matriz1[k*W +: W])) + int'($signed(cop_matriz2[k*W +: W]));
                    res[k*W +: W] = s[7:0];
                    if (s > 127 || s < -128) ovf = 1'b1;
                end
                repeat (2) @(posedge clk);
                #1 cop_result = res; cop_overflow = ovf; cop_done = 1'b1;
                @(posedge clk);
                #1 cop_done = 1'b0; cop_overflow = 1'b1; cop_result = ~res;
            end
        end
    end

    initial begin : cmp
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < N; k++) begin
                    pa[k*W +: W] = m_a[k];
                    pb[k*W +: W] = m_b[k];
                end
                chk("busy", MW'(busy), MW'(m_busy));
                chk("instr_ready", MW'(host_if.instr_ready), MW'(!m_busy));
                chk("cop_start", MW'(cop_start), MW'(m_start));
                chk("flag_done", MW'(flag_done), MW'(m_done));
                chk("flag_ovf", MW'(flag_ovf), MW'(m_ovf));
                chk("flag_err", MW'(flag_err), MW'(m_err));
                chk("cop_op", MW'(cop_op), MW'(m_op));
                chk("cop_tamanho", MW'(cop_tamanho), MW'(m_tam));
                chk("cop_matriz1", cop_matriz1, pa);
                chk("cop_matriz2", cop_matriz2, pb);
                chk("rdata_valid", MW'(host_if.rdata_valid), MW'(m_rvalid));
                if (m_rvalid) chk("rdata", MW'(host_if.rdata), MW'(m_rdata));
            end
        end
    end

    function automatic logic [31:0] mk(input logic [1:0] cmd, input logic [4:0] idx, input logic [7:0] d);
        return {cmd, 17'd0, idx, d};
    endfunction

    // Present one instruction, hold it until accepted; returns aligned 1 time unit after the accept edge
    task automatic send(input logic [31:0] w, input bit en, output int waited);
        exec_cop_en = en;
        host_if.instr = w;
        host_if.instr_valid = 1'b1;
        waited = 0;
        forever begin
            @(posedge clk);
            waited++;
            if (host_if.instr_ready) break;
            if (waited >= 300) begin
                tests++; fails++;
                $display("FAIL send_timeout: instr %h not accepted after %0d cycles", w, waited);
                break;
            end
        end
        #1 host_if.instr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc >= 300) begin
                tests++; fails++;
                $display("FAIL wait_idle: busy still high after %0d cycles", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int         k, cyc, r;
        logic [31:0] w;
        host_if.instr = 32'd0;
        host_if.instr_valid = 1'b0;
        exec_cop_en = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr_ready", MW'(host_if.instr_ready), MW'(1'b1));
        chk("rst_busy", MW'(busy), MW'(1'b0));
        chk("rst_flags", MW'({flag_done, flag_ovf, flag_err, cop_start}), MW'(4'b0000));
        chk("rst_matriz1", cop_matriz1, '0);
        rst_n = 1'b1;

        // 1: 5 + 3 -> 8, single start pulse, 4 busy cycles
        send(mk(2'b00, 5'd0, 8'h05), 1'b1, k);
        send(mk(2'b01, 5'd0, 8'h03), 1'b1, k);
        send(mk(2'b10, 5'd0, {2'b00, 3'd5, 3'b000}), 1'b1, k);
        chk("t1_start", MW'(cop_start), MW'(1'b1));
        wait_idle(cyc);
        chk("t1_busy_cycles", MW'(cyc), MW'(4));
        chk("t1_done_ovf_err", MW'({flag_done, flag_ovf, flag_err}), MW'(3'b100));
        send(mk(2'b11, 5'd0, 8'h00), 1'b1, k);
        chk("t1_rvalid", MW'(host_if.rdata_valid), MW'(1'b1));
        chk("t1_rdata", MW'(host_if.rdata), MW'(8'h08));

        // 2: 0x7F + 0x01 overflows
        send(mk(2'b00, 5'd0, 8'h7F), 1'b1, k);
        send(mk(2'b01, 5'd0, 8'h01), 1'b1, k);
        send(mk(2'b10, 5'd0, 8'h00), 1'b1, k);
        wait_idle(cyc);
        chk("t2_done_ovf_err", MW'({flag_done, flag_ovf, flag_err}), MW'(3'b110));

        // 3: out-of-range LOAD and READ
        send(mk(2'b00, 5'd25, 8'hAA), 1'b1, k);
        chk("t3_err", MW'(flag_err), MW'(1'b1));
        chk("t3_a0", MW'(cop_matriz1[7:0]), MW'(8'h7F));
        send(mk(2'b11, 5'd31, 8'h00), 1'b1, k);
        chk("t3_rvalid", MW'(host_if.rdata_valid), MW'(1'b1));
        chk("t3_rdata", MW'(host_if.rdata), MW'(8'h00));

        // 4: no done -> timeout
        send(mk(2'b10, 5'd0, 8'h2B), 1'b0, k);
        wait_idle(cyc);
        chk("t4_busy_cycles", MW'(cyc), MW'(TO + 1));
        chk("t4_err_done", MW'({flag_err, flag_done}), MW'(2'b10));
        chk("t4_ready", MW'(host_if.instr_ready), MW'(1'b1));

        // 5: LOAD held during WAIT_DONE waits for IDLE
        send(mk(2'b10, 5'd0, 8'h00), 1'b1, k);
        send(mk(2'b00, 5'd3, 8'h5A), 1'b1, k);
        chk("t5_accept_wait", MW'(k), MW'(5));
        chk("t5_a3", MW'(cop_matriz1[31:24]), MW'(8'h5A));
        chk("t5_done", MW'(flag_done), MW'(1'b1));

        // 6: reset mid-operation, late done ignored
        send(mk(2'b10, 5'd0, 8'h00), 1'b1, k);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_flags", MW'({flag_done, flag_ovf, flag_err}), MW'(3'b000));
        chk("t6_idle", MW'({busy, cop_start, host_if.instr_ready}), MW'(3'b001));

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            w = $urandom;
            w[12:8] = 5'($urandom_range(0, 31));
            if (r < 35)      w[31:30] = 2'b00;
            else if (r < 70) w[31:30] = 2'b01;
            else if (r < 85) w[31:30] = 2'b11;
            else             w[31:30] = 2'b10;
            send(w, ($urandom_range(0, 4) != 0), k);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle(cyc);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
